ysyx_040729_idu_issue: RTL and testbench
========================================

Name: ysyx_040729_idu_issue

Overview:
- Parametrised decode/issue stage for the ysyx_040729 in-order pipeline.
- Holds one fetched instruction in an ID register and reads its two sources from the register file.
- Resolves source operands through a configurable number of downstream forwarding stages and stalls on not-yet-available results (load-use).
- Issues into a registered ID/EX slot using valid/ready handshakes on both sides, and counts stall cycles for performance analysis.

Parameters:
- DATA_WIDTH, 64, operand/register width.
- ADDR_WIDTH, 64, PC width.
- INST_WIDTH, 32, instruction width.
- REG_ADDR_W, 5, register address width.
- NUM_FWD, 3, number of forwarding sources (index 0 = youngest, e.g. EX, MEM, WB).
- CNT_W, 32, stall counter width.

Ports:
- clock  in  1  system clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-low reset.
- flush_i  in  1  kill ID and ID/EX contents (redirect/trap).
- if_valid_i  in  1  fetch presents an instruction.
- if_ready_o  out  1  ID can accept this cycle.
- if_inst_i  in  INST_WIDTH  fetched instruction.
- if_pc_i  in  ADDR_WIDTH  fetched PC.
- rf_raddr1_o  out  REG_ADDR_W  instruction bits [19:15] of the ID register.
- rf_raddr2_o  out  REG_ADDR_W  instruction bits [24:20] of the ID register.
- rf_rdata1_i  in  DATA_WIDTH  combinational regfile read data, port 1.
- rf_rdata2_i  in  DATA_WIDTH  combinational regfile read data, port 2.
- fwd_valid_i  in  NUM_FWD  stage k holds a valid instruction.
- fwd_we_i  in  NUM_FWD  stage k writes a register.
- fwd_waddr_i  in  NUM_FWD*REG_ADDR_W  destination of stage k (slice k).
- fwd_data_i  in  NUM_FWD*DATA_WIDTH  result of stage k (slice k).
- fwd_rdy_i  in  NUM_FWD  stage k result is available (0 for a pending load).
- ex_valid_o  out  1  ID/EX slot valid.
- ex_ready_i  in  1  EX consumes the slot this cycle.
- ex_inst_o  out  INST_WIDTH  issued instruction.
- ex_pc_o  out  ADDR_WIDTH  issued PC.
- ex_src1_o  out  DATA_WIDTH  resolved rs1 value.
- ex_src2_o  out  DATA_WIDTH  resolved rs2 value.
- hazard_o  out  1  ID holds an instruction blocked on an unavailable operand.
- stall_cnt_o  out  CNT_W  saturating count of hazard stall cycles.

Behaviour:
- Reset (reset low, asynchronous):
  - id_valid=0 and ex_valid_o=0.
  - ex_inst_o, ex_pc_o, ex_src1_o and ex_src2_o are 0.
  - stall_cnt_o=0.
  - Outputs are clean in the first cycle after reset release.
- ID register:
  - Loads if_inst_i/if_pc_i when if_valid_i & if_ready_o.
  - Otherwise holds its contents.
  - Clears id_valid when the instruction issues and no new instruction is accepted.
- Operand resolution, per source s (combinational):
  - A match at stage k requires raddr_s != 0, fwd_valid_i[k], fwd_we_i[k] and waddr[k] == raddr_s.
  - The lowest matching k wins.
  - If the winning stage has fwd_rdy_i[k]=0, source s is blocked.
  - With no match, the value is rf_rdata_s_i.
  - Register x0 always resolves to 0 and never blocks.
  - Both rs fields are checked for every instruction; this is conservative and spurious stalls are permitted.
- hazard_o = id_valid & (block1 | block2).
- Issue:
  - Condition: issue = id_valid & ~hazard_o & (~ex_valid_o | ex_ready_i) & ~flush_i.
  - On issue the ID/EX registers capture inst, pc and the resolved src1/src2, and ex_valid_o=1.
  - If ex_ready_i & ~issue, ex_valid_o goes to 0 and the data registers hold.
  - Latency: an instruction accepted in cycle t issues at the earliest edge of t+1, and is visible on ex_* in cycle t+2.
- if_ready_o:
  - Equals ~flush_i & (~id_valid | issue).
  - Back-to-back acceptance gives one instruction per cycle.
- Backpressure: with ex_valid_o=1 and ex_ready_i=0, ex_* stay stable and ID holds.
- Flush:
  - On the next edge, id_valid=0 and ex_valid_o=0.
  - The if handshake is refused in the flush cycle.
  - Flush overrides issue and accept in the same cycle.
- Stall counter:
  - Increments by 1 on each edge where hazard_o=1 and flush_i=0.
  - Saturates at all-ones and never wraps.
  - Backpressure-only stall cycles are not counted.
- Simultaneous events:
  - Issue and accept in the same cycle replace the ID content without a bubble.
  - A producer in stage k whose result becomes ready (fwd_rdy_i rising) unblocks the instruction in that same cycle, and it issues at that edge.

Test Plan:
- Reset mid-stream: drive reset low while ex_valid_o=1 -> ex_valid_o=0, if_ready_o=1 and stall_cnt_o=0 immediately; no issue until reset rises.
- Forward priority: stage0 writes x5=0x11, stage1 writes x5=0x22, and ID holds "add x1,x5,x5" -> ex_src1_o=ex_src2_o=0x11. With stage0 invalid -> both are 0x22.
- Load-use: stage0 is a valid load to x7 with fwd_rdy_i[0]=0 and ID reads x7.
  - hazard_o=1 for 1 cycle, if_ready_o=0, stall_cnt_o rises by 1.
  - Next cycle fwd_rdy_i[0]=1 with data 0xDEAD -> issue with ex_src1_o=0xDEAD.
- x0 immunity: stage0 writes x0 with data 0xFF and rdy=0, and ID reads x0 -> no hazard, ex_src1_o=0.
- Backpressure and throughput:
  - Stream 4 instructions with ex_ready_i=1 -> one issue per cycle, PCs 0x80000000..0x8000000C in order.
  - Hold ex_ready_i=0 for 3 cycles -> ex_* stable and stall_cnt_o unchanged.
- Flush and saturation:
  - Assert flush_i with ID and EX both valid -> both invalid next cycle, the fetch in that cycle is not accepted.
  - With CNT_W=2, 5 hazard cycles -> stall_cnt_o=3.

Source files
------------

// File: rtl/ysyx_040729_idu_issue.sv
// Decode/issue stage: one-entry ID register, operand forwarding with
// load-use stall detection, and a registered ID/EX slot with valid/ready
// handshakes. A saturating counter records hazard stall cycles.

// Per-source operand selector: the youngest matching forwarding stage wins,
// otherwise the register file value is used. x0 is hard-wired to zero.
module ysyx_040729_idu_fwd_sel #(
   parameter int DATA_WIDTH = 64,
   parameter int REG_ADDR_W = 5,
   parameter int NUM_FWD    = 3
) (
   input  logic [REG_ADDR_W-1:0]         raddr_i,
   input  logic [DATA_WIDTH-1:0]         rf_data_i,
   input  logic [NUM_FWD-1:0]            fwd_valid_i,
   input  logic [NUM_FWD-1:0]            fwd_we_i,
   input  logic [NUM_FWD-1:0]            fwd_rdy_i,
   input  logic [NUM_FWD*REG_ADDR_W-1:0] fwd_waddr_i,
   input  logic [NUM_FWD*DATA_WIDTH-1:0] fwd_data_i,
   output logic [DATA_WIDTH-1:0]         data_o,
   output logic                          block_o
);
   logic hit;

   // Scan from youngest to oldest; the first hit decides value and readiness.
   always_comb begin
      data_o  = rf_data_i;
      block_o = 1'b0;
      hit     = 1'b0;
      if (raddr_i == '0) begin
         data_o = '0;
      end else begin
         for (int k = 0; k < NUM_FWD; k++) begin
            if (!hit && fwd_valid_i[k] && fwd_we_i[k] &&
                fwd_waddr_i[k*REG_ADDR_W +: REG_ADDR_W] == raddr_i) begin
               hit     = 1'b1;
               data_o  = fwd_data_i[k*DATA_WIDTH +: DATA_WIDTH];
               block_o = ~fwd_rdy_i[k];
            end
         end
      end
   end
endmodule

module ysyx_040729_idu_issue #(
   parameter int DATA_WIDTH = 64,
   parameter int ADDR_WIDTH = 64,
   parameter int INST_WIDTH = 32,
   parameter int REG_ADDR_W = 5,
   parameter int NUM_FWD    = 3,
   parameter int CNT_W      = 32
) (
   input  logic                          clock,
   input  logic                          reset,
   input  logic                          flush_i,
   input  logic                          if_valid_i,
   output logic                          if_ready_o,
   input  logic [INST_WIDTH-1:0]         if_inst_i,
   input  logic [ADDR_WIDTH-1:0]         if_pc_i,
   output logic [REG_ADDR_W-1:0]         rf_raddr1_o,
   output logic [REG_ADDR_W-1:0]         rf_raddr2_o,
   input  logic [DATA_WIDTH-1:0]         rf_rdata1_i,
   input  logic [DATA_WIDTH-1:0]         rf_rdata2_i,
   input  logic [NUM_FWD-1:0]            fwd_valid_i,
   input  logic [NUM_FWD-1:0]            fwd_we_i,
   input  logic [NUM_FWD*REG_ADDR_W-1:0] fwd_waddr_i,
   input  logic [NUM_FWD*DATA_WIDTH-1:0] fwd_data_i,
   input  logic [NUM_FWD-1:0]            fwd_rdy_i,
   output logic                          ex_valid_o,
   input  logic                          ex_ready_i,
   output logic [INST_WIDTH-1:0]         ex_inst_o,
   output logic [ADDR_WIDTH-1:0]         ex_pc_o,
   output logic [DATA_WIDTH-1:0]         ex_src1_o,
   output logic [DATA_WIDTH-1:0]         ex_src2_o,
   output logic                          hazard_o,
   output logic [CNT_W-1:0]              stall_cnt_o
);
   logic                  id_valid_q, id_valid_d;
   logic [INST_WIDTH-1:0] id_inst_q, id_inst_d;
   logic [ADDR_WIDTH-1:0] id_pc_q, id_pc_d;
   logic                  ex_valid_q, ex_valid_d;
   logic [INST_WIDTH-1:0] ex_inst_q, ex_inst_d;
   logic [ADDR_WIDTH-1:0] ex_pc_q, ex_pc_d;
   logic [DATA_WIDTH-1:0] ex_src1_q, ex_src1_d, ex_src2_q, ex_src2_d;
   logic [CNT_W-1:0]      stall_q, stall_d;

   logic [1:0][REG_ADDR_W-1:0] raddr;
   logic [1:0][DATA_WIDTH-1:0] rf_data, opnd;
   logic [1:0]                 blk;
   logic                       issue, accept;

   assign raddr[0]    = id_inst_q[19:15];
   assign raddr[1]    = id_inst_q[24:20];
   assign rf_data[0]  = rf_rdata1_i;
   assign rf_data[1]  = rf_rdata2_i;
   assign rf_raddr1_o = raddr[0];
   assign rf_raddr2_o = raddr[1];

   for (genvar s = 0; s < 2; s++) begin : g_src
      ysyx_040729_idu_fwd_sel #(
         .DATA_WIDTH (DATA_WIDTH),
         .REG_ADDR_W (REG_ADDR_W),
         .NUM_FWD    (NUM_FWD)
      ) u_sel (
         .raddr_i     (raddr[s]),
         .rf_data_i   (rf_data[s]),
         .fwd_valid_i (fwd_valid_i),
         .fwd_we_i    (fwd_we_i),
         .fwd_rdy_i   (fwd_rdy_i),
         .fwd_waddr_i (fwd_waddr_i),
         .fwd_data_i  (fwd_data_i),
         .data_o      (opnd[s]),
         .block_o     (blk[s])
      );
   end

   // Both rs fields are checked regardless of format, so some stalls are spurious.
   assign hazard_o   = id_valid_q & (blk[0] | blk[1]);
   assign issue      = id_valid_q & ~hazard_o & (~ex_valid_q | ex_ready_i) & ~flush_i;
   assign if_ready_o = ~flush_i & (~id_valid_q | issue);
   assign accept     = if_valid_i & if_ready_o;

   assign ex_valid_o  = ex_valid_q;
   assign ex_inst_o   = ex_inst_q;
   assign ex_pc_o     = ex_pc_q;
   assign ex_src1_o   = ex_src1_q;
   assign ex_src2_o   = ex_src2_q;
   assign stall_cnt_o = stall_q;

   // ID register: flush kills, accept replaces (even while issuing), issue empties.
   always_comb begin
      id_valid_d = id_valid_q;
      id_inst_d  = id_inst_q;
      id_pc_d    = id_pc_q;
      if (flush_i) begin
         id_valid_d = 1'b0;
      end else if (accept) begin
         id_valid_d = 1'b1;
         id_inst_d  = if_inst_i;
         id_pc_d    = if_pc_i;
      end else if (issue) begin
         id_valid_d = 1'b0;
      end
   end

   // ID/EX slot: data only moves on issue, so backpressure keeps it stable.
   always_comb begin
      ex_valid_d = ex_valid_q;
      ex_inst_d  = ex_inst_q;
      ex_pc_d    = ex_pc_q;
      ex_src1_d  = ex_src1_q;
      ex_src2_d  = ex_src2_q;
      if (flush_i) begin
         ex_valid_d = 1'b0;
      end else if (issue) begin
         ex_valid_d = 1'b1;
         ex_inst_d  = id_inst_q;
         ex_pc_d    = id_pc_q;
         ex_src1_d  = opnd[0];
         ex_src2_d  = opnd[1];
      end else if (ex_ready_i) begin
         ex_valid_d = 1'b0;
      end
   end

   // Hazard stall counter, saturating at all-ones.
   always_comb begin
      stall_d = stall_q;
      if (hazard_o && !flush_i && stall_q != {CNT_W{1'b1}})
         stall_d = stall_q + CNT_W'(1);
   end

   // State registers.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         id_valid_q <= 1'b0;
         id_inst_q  <= '0;
         id_pc_q    <= '0;
         ex_valid_q <= 1'b0;
         ex_inst_q  <= '0;
         ex_pc_q    <= '0;
         ex_src1_q  <= '0;
         ex_src2_q  <= '0;
         stall_q    <= '0;
      end else begin
         id_valid_q <= id_valid_d;
         id_inst_q  <= id_inst_d;
         id_pc_q    <= id_pc_d;
         ex_valid_q <= ex_valid_d;
         ex_inst_q  <= ex_inst_d;
         ex_pc_q    <= ex_pc_d;
         ex_src1_q  <= ex_src1_d;
         ex_src2_q  <= ex_src2_d;
         stall_q    <= stall_d;
      end
   end
endmodule

// File: tb/tb_ysyx_040729_idu_issue.sv
// Scoreboard bench for ysyx_040729_idu_issue: expected EX transfers are
// queued on fetch acceptance and checked by a monitor on each EX handshake.
module tb_ysyx_040729_idu_issue;
   logic             clock = 1'b0;
   logic             reset = 1'b0;
   logic             flush = 1'b0;
   logic             if_valid = 1'b0;
   logic             if_ready;
   logic [31:0]      if_inst = '0;
   logic [63:0]      if_pc = '0;
   logic [4:0]       raddr1, raddr2;
   logic [63:0]      rdata1, rdata2;
   logic [2:0]       fv = '0, fw = '0, frdy = '1;
   logic [2:0][4:0]  fa = '0;
   logic [2:0][63:0] fd = '0;
   logic             ex_valid, ex_ready = 1'b1;
   logic [31:0]      ex_inst;
   logic [63:0]      ex_pc, ex_src1, ex_src2;
   logic             hazard;
   logic [1:0]       stall_cnt;

   typedef struct {
      logic [31:0] inst;
      logic [63:0] pc, s1, s2;
   } exp_t;

   exp_t sb[$];
   int   xfer_cyc[$];
   int   checks = 0, errors = 0, cyc = 0;
   bit   rnd_mode = 0;
   int   exp_stall = 0;

   always #5 clock = ~clock;

   ysyx_040729_idu_issue #(.CNT_W(2)) dut (
      .clock(clock), .reset(reset), .flush_i(flush),
      .if_valid_i(if_valid), .if_ready_o(if_ready), .if_inst_i(if_inst), .if_pc_i(if_pc),
      .rf_raddr1_o(raddr1), .rf_raddr2_o(raddr2), .rf_rdata1_i(rdata1), .rf_rdata2_i(rdata2),
      .fwd_valid_i(fv), .fwd_we_i(fw), .fwd_waddr_i(fa), .fwd_data_i(fd), .fwd_rdy_i(frdy),
      .ex_valid_o(ex_valid), .ex_ready_i(ex_ready), .ex_inst_o(ex_inst), .ex_pc_o(ex_pc),
      .ex_src1_o(ex_src1), .ex_src2_o(ex_src2), .hazard_o(hazard), .stall_cnt_o(stall_cnt)
   );

   // Register file contents: distinct, nonzero even for x0.
   function automatic logic [63:0] rfval(logic [4:0] a);
      return 64'hC0DE_0000_0000_0100 + {59'd0, a};
   endfunction

   assign rdata1 = rfval(raddr1);
   assign rdata2 = rfval(raddr2);

   // Architectural value a reader of register r sees given the producers in flight.
   function automatic logic [63:0] resolve(logic [4:0] r);
      if (r == 5'd0) return 64'd0;
      for (int k = 0; k < 3; k++)
         if (fv[k] && fw[k] && fa[k] == r) return fd[k];
      return rfval(r);
   endfunction

   function automatic logic [31:0] mk(int rs1, int rs2, int rd);
      logic [4:0] a, b, d;
      a = rs1[4:0]; b = rs2[4:0]; d = rd[4:0];
      return {7'd0, b, a, 3'd0, d, 7'h33};
   endfunction

   task automatic chk(string name, logic [63:0] got, logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%h exp=%h", name, got, exp);
      end
   endtask

   task automatic ticker();
      forever begin
         @(posedge clock);
         cyc++;
         #1;
         if (rnd_mode) begin
            frdy     = 3'($urandom);
            ex_ready = 1'($urandom);
         end
      end
   endtask

   task automatic monitor();
      exp_t        e;
      bit          hold = 0;
      logic [31:0] pi;
      logic [63:0] pp, p1;
      forever begin
         @(negedge clock);
         if (!reset) begin
            hold = 0;
         end else begin
            if (hold && ex_valid) begin
               chk("stable_inst", {32'd0, ex_inst}, {32'd0, pi});
               chk("stable_pc", ex_pc, pp);
               chk("stable_src1", ex_src1, p1);
            end
            if (ex_valid && ex_ready) begin
               xfer_cyc.push_back(cyc);
               if (sb.size() == 0) begin
                  checks++; errors++;
                  $display("FAIL unexpected_issue pc=%h", ex_pc);
               end else begin
                  e = sb.pop_front();
                  chk("ex_inst", {32'd0, ex_inst}, {32'd0, e.inst});
                  chk("ex_pc", ex_pc, e.pc);
                  chk("ex_src1", ex_src1, e.s1);
                  chk("ex_src2", ex_src2, e.s2);
               end
            end
            hold = ex_valid && !ex_ready;
            pi = ex_inst; pp = ex_pc; p1 = ex_src1;
         end
      end
   endtask

   task automatic step();
      @(posedge clock); #1;
   endtask

   task automatic send(logic [31:0] inst, logic [63:0] pc);
      exp_t e;
      bit   ok = 0;
      if_valid = 1; if_inst = inst; if_pc = pc;
      for (int i = 0; i < 300 && !ok; i++) begin
         @(negedge clock);
         if (if_ready && reset && !flush) ok = 1;
      end
      if (!ok) begin
         checks++; errors++;
         $display("FAIL accept_timeout pc=%h", pc);
         if_valid = 0;
         return;
      end
      e.inst = inst; e.pc = pc;
      e.s1 = resolve(inst[19:15]); e.s2 = resolve(inst[24:20]);
      sb.push_back(e);
      step();
      if_valid = 0;
   endtask

   task automatic drain();
      bit ok = 0;
      for (int i = 0; i < 300 && !ok; i++) begin
         @(negedge clock);
         if (sb.size() == 0) ok = 1;
      end
      if (!ok) begin
         checks++; errors++;
         $display("FAIL drain_timeout left=%0d", sb.size());
         sb.delete();
      end
      step();
   endtask

   initial begin
      fork
         ticker();
         monitor();
      join_none

      // Reset state, then outputs clean after release.
      repeat (2) @(posedge clock);
      @(negedge clock);
      chk("rst_ex_valid", {63'd0, ex_valid}, 64'd0);
      chk("rst_if_ready", {63'd0, if_ready}, 64'd1);
      chk("rst_stall", {62'd0, stall_cnt}, 64'd0);
      chk("rst_ex_pc", ex_pc, 64'd0);
      chk("rst_ex_src1", ex_src1, 64'd0);
      step(); reset = 1;
      @(negedge clock);
      chk("post_rst_ex_valid", {63'd0, ex_valid}, 64'd0);
      chk("post_rst_hazard", {63'd0, hazard}, 64'd0);
      step();

      // Forward priority: youngest producer wins, then the older one.
      fv = 3'b011; fw = 3'b011; fa[0] = 5; fa[1] = 5; fd[0] = 64'h11; fd[1] = 64'h22;
      send(mk(5, 5, 1), 64'h8000_0000);
      drain();
      fv = 3'b010;
      send(mk(5, 5, 1), 64'h8000_0004);
      drain();

      // Load-use: one hazard cycle, then same-cycle unblock on ready.
      fv = 3'b001; fw = 3'b001; fa[0] = 7; fd[0] = 64'hDEAD; frdy = 3'b110;
      send(mk(7, 0, 2), 64'h8000_0008);
      @(negedge clock);
      chk("lu_hazard", {63'd0, hazard}, 64'd1);
      chk("lu_if_ready", {63'd0, if_ready}, 64'd0);
      chk("lu_stall_before", {62'd0, stall_cnt}, 64'(exp_stall));
      step(); exp_stall++;
      frdy = 3'b111;
      @(negedge clock);
      chk("lu_unblocked", {63'd0, hazard}, 64'd0);
      chk("lu_stall_after", {62'd0, stall_cnt}, 64'(exp_stall));
      drain();

      // x0 is immune to a pending write to x0.
      fv = 3'b001; fw = 3'b001; fa[0] = 0; fd[0] = 64'hFF; frdy = 3'b110;
      send(mk(0, 0, 3), 64'h8000_000C);
      @(negedge clock);
      chk("x0_hazard", {63'd0, hazard}, 64'd0);
      drain();
      frdy = 3'b111; fv = 3'b000;

      // Throughput: four back-to-back instructions, one issue per cycle.
      xfer_cyc.delete();
      for (int i = 0; i < 4; i++) send(mk(i + 1, i + 2, 9), 64'h8000_0000 + 64'(4 * i));
      drain();
      chk("tput_count", 64'(xfer_cyc.size()), 64'd4);
      if (xfer_cyc.size() == 4)
         chk("tput_span", 64'(xfer_cyc[3] - xfer_cyc[0]), 64'd3);

      // Backpressure: EX held, ID holds, fetch refused, counter untouched.
      ex_ready = 0;
      send(mk(1, 2, 3), 64'h8000_0100);
      send(mk(3, 4, 5), 64'h8000_0104);
      if_valid = 1; if_inst = mk(6, 6, 6); if_pc = 64'h8000_0108;
      for (int i = 0; i < 3; i++) begin
         @(negedge clock);
         chk("bp_if_ready", {63'd0, if_ready}, 64'd0);
         chk("bp_ex_valid", {63'd0, ex_valid}, 64'd1);
         chk("bp_stall", {62'd0, stall_cnt}, 64'(exp_stall));
         step();
      end
      if_valid = 0; ex_ready = 1;
      drain();

      // Flush with ID and EX both valid.
      ex_ready = 0;
      send(mk(1, 1, 1), 64'h8000_0200);
      send(mk(2, 2, 2), 64'h8000_0204);
      flush = 1; if_valid = 1; if_inst = mk(3, 3, 3); if_pc = 64'h8000_0208;
      @(negedge clock);
      chk("fl_if_ready", {63'd0, if_ready}, 64'd0);
      step();
      flush = 0; if_valid = 0; sb.delete();
      @(negedge clock);
      chk("fl_ex_valid", {63'd0, ex_valid}, 64'd0);
      chk("fl_id_empty", {63'd0, if_ready}, 64'd1);
      step(); ex_ready = 1;
      repeat (3) step();
      chk("fl_no_issue", {63'd0, ex_valid}, 64'd0);

      // Saturation of the 2-bit counter over five hazard cycles.
      fv = 3'b001; fw = 3'b001; fa[0] = 7; fd[0] = 64'hBEEF; frdy = 3'b110;
      send(mk(7, 0, 4), 64'h8000_0300);
      for (int i = 0; i < 5; i++) begin
         @(negedge clock);
         chk("sat_hazard", {63'd0, hazard}, 64'd1);
         chk("sat_stall", {62'd0, stall_cnt}, 64'((exp_stall + i > 3) ? 3 : exp_stall + i));
         step();
      end
      frdy = 3'b111;
      @(negedge clock);
      chk("sat_final", {62'd0, stall_cnt}, 64'd3);
      drain();
      fv = 3'b000;

      // Reset mid-stream with EX valid.
      ex_ready = 0;
      send(mk(1, 2, 3), 64'h8000_0400);
      step();
      chk("mr_ex_valid_pre", {63'd0, ex_valid}, 64'd1);
      reset = 0; #1;
      chk("mr_ex_valid", {63'd0, ex_valid}, 64'd0);
      chk("mr_if_ready", {63'd0, if_ready}, 64'd1);
      chk("mr_stall", {62'd0, stall_cnt}, 64'd0);
      sb.delete(); exp_stall = 0;
      if_valid = 1; if_inst = mk(4, 4, 4); ex_ready = 1;
      repeat (2) begin
         @(negedge clock);
         chk("mr_held", {63'd0, ex_valid}, 64'd0);
      end
      step(); if_valid = 0; reset = 1;
      step();

      // Randomized epochs: static producer table, random readiness and backpressure.
      for (int ep = 0; ep < 8; ep++) begin
         for (int k = 0; k < 3; k++) begin
            fv[k] = 1'($urandom); fw[k] = 1'($urandom);
            fa[k] = 5'($urandom_range(0, 7)); fd[k] = {$urandom, $urandom};
         end
         rnd_mode = 1;
         for (int n = 0; n < 20; n++) begin
            send(mk($urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 31)),
                 {32'h8000_0000, 32'($urandom) & 32'hFFFF_FFFC});
            repeat ($urandom_range(0, 2)) step();
         end
         rnd_mode = 0;
         @(posedge clock); #2;
         frdy = 3'b111; ex_ready = 1;
         drain();
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
